mul_fpu_fsm: RTL and testbench

Multi-cycle IEEE-754 single-precision multiplier. It is the multiplicative counterpart to the FPU divide unit and shares the same start/busy/done handshake, so the RV32IMF execute stage can issue FMUL.S through the same sequencer as FDIV.S. The core is a sequential shift-add over the 24-bit significands, followed by normalize, round and pack. Special operands (zero, infinity, NaN) bypass the datapath.

---
 rtl/fpu_pkg.sv | 38 +++
 rtl/fpu_unpack.sv | 26 ++
 rtl/mul_fpu_fsm.sv | 224 ++++++++++++++++++++++
 tb/tb_mul_fpu_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: definitions shared by the FPU multiply and divide units.
//   - state_t    : sequencer state encoding (IDLE..DONE)
//   - op_class_t : operand classification (zero, normal, inf, nan)
//   - operand_t  : unpacked operand (sign, biased exponent, 24-bit significand, class)
//   - EXP_W, MANT_W, BIAS, QNAN, EXP_MAX : IEEE-754 single-precision constants
package fpu_pkg;

  localparam int          EXP_W   = 8;
  localparam int          MANT_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]  EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UNPACK    = 3'd1,
    ST_INIT      = 3'd2,
    ST_MULTIPLY  = 3'd3,
    ST_NORMALIZE = 3'd4,
    ST_PACK      = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } op_class_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W:0]   mant;   // hidden bit included
    op_class_t         cls;
  } operand_t;

endpackage

// File: rtl/fpu_unpack.sv
// fpu_unpack: combinational field splitter and classifier for one IEEE single.
// Ports:
//   value (in, 32)  raw IEEE-754 single-precision word
//   op    (out)     operand_t: sign, biased exponent, significand with hidden
//                   bit, class. Denormals are flushed: class zero, significand 0.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] value,
  output operand_t    op
);

  always_comb begin
    op.sign = value[31];
    op.exp  = value[30:23];
    op.mant = {1'b1, value[22:0]};
    op.cls  = CLS_NORMAL;
    if (value[30:23] == '0) begin
      op.cls  = CLS_ZERO;
      op.mant = '0;
    end else if (value[30:23] == EXP_MAX) begin
      op.cls = (value[22:0] != '0) ? CLS_NAN : CLS_INF;
    end
  end

endmodule

// File: rtl/mul_fpu_fsm.sv
// mul_fpu_fsm: multi-cycle IEEE-754 single-precision multiplier.
// Sequential shift-add over the 24-bit significands, then normalize, round, pack.
// Zero / inf / NaN operands are resolved at unpack time and override the packed
// result, but the multiply still runs so latency does not depend on data.
//
// Optional build macro MUL_FPU_ROUND_NEAREST_EN: round-to-nearest-even.
// Without it the mantissa is truncated and no round adder exists.
//
// Parameters:
//   BITS_PER_CYCLE  multiplier bits consumed per MULTIPLY cycle (1, 2 or 4)
//   BIAS            exponent bias (127 only)
// Ports:
//   clk        (in)      rising-edge clock
//   rst        (in)      asynchronous active-low reset
//   start      (in)      request, sampled only in IDLE
//   N1, N2     (in, 32)  operands, latched on the accepting edge
//   result     (out, 32) product, written when leaving PACK, held until the next PACK
//   done       (out)     high in DONE
//   busy       (out)     high in UNPACK..PACK
//   fsm_state  (out)     current sequencer state
//
// Handshake (four-phase): in IDLE, start=1 is accepted on a rising edge; busy
// stays high while the operation runs and start is ignored; done then stays high
// until start is seen low, after which the unit returns to IDLE on the next edge.
module mul_fpu_fsm
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int BIAS           = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] N1,
  input  logic [31:0] N2,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output state_t      fsm_state
);

  localparam int         MUL_CYCLES = 24 / BITS_PER_CYCLE;
  localparam logic [4:0] CNT_LAST   = 5'(MUL_CYCLES - 1);

  state_t state_q, state_next;

  logic [31:0]        a_q, b_q;
  operand_t           a_op, b_op;
  logic               special_q;
  logic [31:0]        special_val_q;
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        mcand_q;
  logic [23:0]        mplier_q;
  logic [47:0]        acc_q, acc_next;
  logic [4:0]         count_q;
  logic [22:0]        mant_q;
`ifdef MUL_FPU_ROUND_NEAREST_EN
  logic               guard_q, sticky_q;
  logic [23:0]        mant_sum;
`endif

  logic               is_special;
  logic [31:0]        special_val;
  logic signed [9:0]  exp_r;
  logic [22:0]        mant_r;
  logic [31:0]        pack_val;

  assign fsm_state = state_q;

  fpu_unpack u_unpack_a (.value(a_q), .op(a_op));
  fpu_unpack u_unpack_b (.value(b_q), .op(b_op));

  // Special-operand priority: NaN or inf*zero, then inf, then zero.
  always_comb begin
    logic any_nan, any_inf, any_zero, sgn;
    any_nan  = (a_op.cls == CLS_NAN)  || (b_op.cls == CLS_NAN);
    any_inf  = (a_op.cls == CLS_INF)  || (b_op.cls == CLS_INF);
    any_zero = (a_op.cls == CLS_ZERO) || (b_op.cls == CLS_ZERO);
    sgn      = a_op.sign ^ b_op.sign;
    is_special  = any_nan || any_inf || any_zero;
    special_val = {sgn, 31'b0};
    if (any_nan || (any_inf && any_zero)) begin
      special_val = QNAN;
    end else if (any_inf) begin
      special_val = {sgn, EXP_MAX, 23'b0};
    end
  end

  // One shift-add step: each low multiplier bit adds the multiplicand at its weight.
  always_comb begin
    acc_next = acc_q;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) acc_next = acc_next + (mcand_q << i);
    end
  end

  // Rounding and final packing of the normalized product.
  always_comb begin
    exp_r  = exp_q;
    mant_r = mant_q;
`ifdef MUL_FPU_ROUND_NEAREST_EN
    mant_sum = {1'b0, mant_q} + 24'(guard_q & (sticky_q | mant_q[0]));
    if (mant_sum[23]) begin
      exp_r  = exp_q + 10'sd1;
      mant_r = '0;
    end else begin
      mant_r = mant_sum[22:0];
    end
`endif
    if (exp_r >= 10'sd255) begin
      pack_val = {sign_q, EXP_MAX, 23'b0};
    end else if (exp_r <= 10'sd0) begin
      pack_val = {sign_q, 31'b0};
    end else begin
      pack_val = {sign_q, exp_r[7:0], mant_r};
    end
  end

`ifndef MUL_FPU_ROUND_NEAREST_EN
  // Bits below the guard position only matter when rounding.
  logic unused_lsbs;
  assign unused_lsbs = ^acc_q[22:0];
`endif

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_next = ST_UNPACK;
      ST_UNPACK:    state_next = ST_INIT;
      ST_INIT:      state_next = ST_MULTIPLY;
      ST_MULTIPLY:  if (count_q == CNT_LAST) state_next = ST_NORMALIZE;
      ST_NORMALIZE: state_next = ST_PACK;
      ST_PACK:      state_next = ST_DONE;
      ST_DONE:      if (!start) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_next;
      busy    <= (state_next == ST_UNPACK) || (state_next == ST_INIT) ||
                 (state_next == ST_MULTIPLY) || (state_next == ST_NORMALIZE) ||
                 (state_next == ST_PACK);
      done    <= (state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q           <= '0;
      b_q           <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      count_q       <= '0;
      mant_q        <= '0;
`ifdef MUL_FPU_ROUND_NEAREST_EN
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
`endif
      result        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q <= N1;
            b_q <= N2;
          end
        end
        ST_UNPACK: begin
          special_q     <= is_special;
          special_val_q <= special_val;
        end
        ST_INIT: begin
          acc_q    <= '0;
          mcand_q  <= {24'b0, a_op.mant};
          mplier_q <= b_op.mant;
          count_q  <= '0;
          exp_q    <= 10'({2'b00, a_op.exp}) + 10'({2'b00, b_op.exp}) - 10'(BIAS);
          sign_q   <= a_op.sign ^ b_op.sign;
        end
        ST_MULTIPLY: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          count_q  <= count_q + 5'd1;
        end
        ST_NORMALIZE: begin
          // Product of two [1,2) significands lies in [1,4): at most one shift.
          if (acc_q[47]) begin
            mant_q   <= acc_q[46:24];
            exp_q    <= exp_q + 10'sd1;
`ifdef MUL_FPU_ROUND_NEAREST_EN
            guard_q  <= acc_q[23];
            sticky_q <= |acc_q[22:0];
`endif
          end else begin
            mant_q   <= acc_q[45:23];
`ifdef MUL_FPU_ROUND_NEAREST_EN
            guard_q  <= acc_q[22];
            sticky_q <= |acc_q[21:0];
`endif
          end
        end
        ST_PACK: begin
          result <= special_q ? special_val_q : pack_val;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_fpu_fsm.sv
// tb_mul_fpu_fsm: self-checking bench for mul_fpu_fsm.
// Driver issues operations and pushes the reference product into exp_q; a
// monitor pops and compares each time done rises. Reference model works on
// real-number rules (integer significand product, remainder-based rounding).
module tb_mul_fpu_fsm;
  import fpu_pkg::*;

  localparam int BPC     = 1;
  localparam int LATENCY = 4 + 24 / BPC + 1;
`ifdef MUL_FPU_ROUND_NEAREST_EN
  localparam bit ROUND_NEAREST = 1'b1;
`else
  localparam bit ROUND_NEAREST = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] n1 = '0;
  logic [31:0] n2 = '0;
  logic [31:0] result;
  logic        done;
  logic        busy;
  state_t      fsm_state;

  always #5 clk = ~clk;

  mul_fpu_fsm #(.BITS_PER_CYCLE(BPC), .BIAS(127)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .N1        (n1),
    .N2        (n2),
    .result    (result),
    .done      (done),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference product from the IEEE rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    bit               s;
    int               ea, eb, e;
    bit               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint unsigned  ma, mb, p, m, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    nan_a  = (ea == 255) && (a[22:0] != 0);
    nan_b  = (eb == 255) && (b[22:0] != 0);
    inf_a  = (ea == 255) && (a[22:0] == 0);
    inf_b  = (eb == 255) && (b[22:0] == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || ((inf_a || inf_b) && (zero_a || zero_b))) return 32'h7FC0_0000;
    if (inf_a || inf_b) return {s, 8'hFF, 23'b0};
    if (zero_a || zero_b) return {s, 31'b0};
    ma = (64'd1 << 23) + 64'(a[22:0]);
    mb = (64'd1 << 23) + 64'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin
      m    = p >> 24;
      rem  = p % (64'd1 << 24);
      half = 64'd1 << 23;
      e    = e + 1;
    end else begin
      m    = p >> 23;
      rem  = p % (64'd1 << 23);
      half = 64'd1 << 22;
    end
    if (ROUND_NEAREST && ((rem > half) || ((rem == half) && (m % 2 == 1)))) begin
      m = m + 1;
      if (m == (64'd1 << 24)) begin
        m = 64'd1 << 23;
        e = e + 1;
      end
    end
    if (e >= 255) return {s, 8'hFF, 23'b0};
    if (e <= 0)   return {s, 31'b0};
    return {s, 8'(e), 23'(m)};
  endfunction

  // ---------------- monitor ----------------
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      done_prev = 1'b0;
    end else begin
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got result %h with empty queue at %0t", result, $time);
        end else begin
          check("result", result, exp_q.pop_front());
          check("busy_with_done", 32'(busy), 32'd0);
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_idle();
    for (int i = 0; i < 100 && !(fsm_state == ST_IDLE && !done); i++) @(negedge clk);
  endtask

  // Issue one operation; hold start for 'hold' cycles in DONE, then release.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input bit timing);
    int edges;
    int busy_cnt;
    wait_idle();
    @(negedge clk);
    n1 = a;
    n2 = b;
    start = 1'b1;
    exp_q.push_back(ref_mul(a, b));
    @(posedge clk);
    edges = 1;          // edges counted including the accepting edge
    busy_cnt = 0;
    @(negedge clk);
    while (!done && edges < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d edges, expected %0d", edges, LATENCY);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end else if (timing) begin
      check("latency", 32'(edges), 32'(LATENCY));
      check("busy_cycles", 32'(busy_cnt), 32'(LATENCY - 1));
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("done_hold", 32'(done), 32'd1);
      check("state_hold", 32'(fsm_state), 32'(ST_DONE));
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check("back_to_idle", 32'(fsm_state), 32'(ST_IDLE));
    check("done_clear", 32'(done), 32'd0);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] specials [7];
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h0040_0000};
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return specials[$urandom_range(0, 6)];
      2:       return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(90, 164)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with known answers.
    run_op(32'h4040_0000, 32'h4000_0000, 0, 1'b1);
    check("dir_3x2_model", ref_mul(32'h4040_0000, 32'h4000_0000), 32'h40C0_0000);
    run_op(32'hBFC0_0000, 32'h3FC0_0000, 5, 1'b1);
    run_op(32'h0000_0000, 32'hC2F6_0000, 0, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 0, 1'b0);
    run_op(32'hFF80_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'h7F00_0000, 32'h4000_0000, 0, 1'b0);
    run_op(32'h0080_0000, 32'h3F00_0000, 0, 1'b0);
    run_op(32'h3F80_0001, 32'h3FC0_0000, 0, 1'b0);
    check("dir_tie_model", ref_mul(32'h3F80_0001, 32'h3FC0_0000),
          ROUND_NEAREST ? 32'h3FC0_0002 : 32'h3FC0_0001);

    // Reset in the middle of MULTIPLY aborts without writing a result.
    wait_idle();
    @(negedge clk);
    n1 = 32'h3FC0_0000;
    n2 = 32'h4100_0000;
    start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("abort_in_multiply", 32'(fsm_state), 32'(ST_MULTIPLY));
    #2;
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_state", 32'(fsm_state), 32'(ST_IDLE));
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h4040_0000, 32'h4000_0000, 0, 1'b1);

    // Randomized operations.
    for (int k = 0; k < 40; k++) begin
      run_op(rand_operand(), rand_operand(), $urandom_range(0, 2), (k % 8) == 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: got no finish by %0t, expected completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
